channel_sample_reorder_buffer: RTL

- Upstream stage of the DRAM write controller; one instance per board, eight instances feed the controller's 8-bit ready mask and read-request mask.
- Takes the time-major ADC sample stream (channels 0..NUM_CHANNELS-1 for time t, then t+1, and so on) and regroups it into channel-major 256-bit words, each holding 16 consecutive samples of one channel.
- Ping-pong double-buffered, so one bank fills while the other is drained.
- Each drained block is one timestamp word followed by NUM_CHANNELS channel words (125 words at default).

---
 rtl/channel_sample_reorder_buffer.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/channel_sample_reorder_buffer.sv
`timescale 1ns/1ps
// channel_sample_reorder_buffer
//
// Regroups a time-major ADC sample stream (channel 0..NUM_CHANNELS-1 for time
// t, then t+1, ...) into channel-major words of SAMPLES_PER_WORD consecutive
// samples of one channel. Two banks ping-pong: one fills while the other
// drains. A drained block is one timestamp word followed by NUM_CHANNELS
// channel words.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          sample beat valid (no backpressure; every beat is taken)
//   in_sof            start of time slice, marks the channel-0 beat
//   in_sample         sample value
//   in_timestamp      captured on the first beat of a block
//   BRAM_rd_request   read one word from the drain bank
//   BRAM_ready_mask   a full block is available to drain
//   BRAM_rd_data      read data, valid the cycle after an accepted request
//   clear_status      synchronous clear of overflow / seq_error / drop_count
//   overflow          sticky: a slice was dropped because no bank was free
//   seq_error         sticky: slice framing violation
//   drop_count        dropped slices, saturating
//
// Handshake: a read word is transferred on every cycle where
// BRAM_rd_request && BRAM_ready_mask; the word appears on BRAM_rd_data on the
// following cycle and holds until the next transfer.
module channel_sample_reorder_buffer #(
    parameter int NUM_CHANNELS     = 124,
    parameter int SAMPLES_PER_WORD = 16,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int TS_WIDTH         = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    input  logic                                     in_sof,
    input  logic [SAMPLE_WIDTH-1:0]                  in_sample,
    input  logic [TS_WIDTH-1:0]                      in_timestamp,
    input  logic                                     BRAM_rd_request,
    output logic                                     BRAM_ready_mask,
    output logic [SAMPLES_PER_WORD*SAMPLE_WIDTH-1:0] BRAM_rd_data,
    input  logic                                     clear_status,
    output logic                                     overflow,
    output logic                                     seq_error,
    output logic [15:0]                              drop_count
);

    localparam int W     = SAMPLES_PER_WORD * SAMPLE_WIDTH;
    localparam int CW    = $clog2(NUM_CHANNELS);
    localparam int TW    = $clog2(SAMPLES_PER_WORD);
    localparam int PW    = $clog2(NUM_CHANNELS + 1);
    localparam int DEPTH = 2 * NUM_CHANNELS;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_DROP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];

    wr_state_t         wr_state, wr_state_d;
    logic              wr_bank, wr_bank_d;
    logic [CW-1:0]     chan_cnt, chan_cnt_d;
    logic [TW-1:0]     time_idx, time_idx_d;

    rd_state_t         rd_state, rd_state_d;
    logic              rd_bank, rd_bank_d;
    logic [PW-1:0]     rd_ptr, rd_ptr_d;
    logic              ready_d;

    logic [W-1:0]        mem [DEPTH];
    logic [TS_WIDTH-1:0] ts_q [2];

    logic          slice_start, mem_we, fill_start, fill_done, drop_evt, seq_evt;
    logic [CW-1:0] mem_chan, rd_chan;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          rd_fire, rd_last, drain_start;

    // ---------------- write FSM ----------------
    always_comb begin
        wr_state_d  = wr_state;
        wr_bank_d   = wr_bank;
        chan_cnt_d  = chan_cnt;
        time_idx_d  = time_idx;
        mem_we      = 1'b0;
        mem_chan    = chan_cnt;
        fill_start  = 1'b0;
        fill_done   = 1'b0;
        drop_evt    = 1'b0;
        seq_evt     = 1'b0;
        slice_start = in_valid & in_sof;

        case (wr_state)
            WR_IDLE, WR_DROP: begin
                if (slice_start) begin
                    if (bank_q[wr_bank] == B_EMPTY) begin
                        fill_start = 1'b1;
                        mem_we     = 1'b1;
                        mem_chan   = '0;
                        wr_state_d = WR_FILL;
                    end else begin
                        drop_evt   = 1'b1;
                        wr_state_d = WR_DROP;
                    end
                end else if (in_valid && wr_state == WR_IDLE) begin
                    // A non-sof beat with no slice open is a framing error.
                    seq_evt = 1'b1;
                end
            end
            WR_FILL: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // sof always restarts the slice at channel 0 of the
                        // current time index; mid-slice it is also an error.
                        seq_evt  = (chan_cnt != '0);
                        mem_we   = 1'b1;
                        mem_chan = '0;
                    end else if (chan_cnt == '0) begin
                        seq_evt = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        if (mem_we) begin
            if (mem_chan == CW'(NUM_CHANNELS - 1)) begin
                chan_cnt_d = '0;
                time_idx_d = time_idx + TW'(1);
                if (time_idx == TW'(SAMPLES_PER_WORD - 1)) begin
                    fill_done  = 1'b1;
                    time_idx_d = '0;
                    wr_bank_d  = ~wr_bank;
                    wr_state_d = WR_IDLE;
                end
            end else begin
                chan_cnt_d = mem_chan + CW'(1);
            end
        end
    end

    assign wr_addr = wr_bank ? AW'(NUM_CHANNELS) + AW'(mem_chan) : AW'(mem_chan);

    // Storage: one lane (one time index) of one channel word per beat.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_addr][int'(time_idx)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= in_sample;
        if (fill_start)
            ts_q[wr_bank] <= in_timestamp;
    end

    // ---------------- read FSM ----------------
    assign rd_fire = BRAM_rd_request & BRAM_ready_mask;

    always_comb begin
        rd_state_d  = rd_state;
        rd_bank_d   = rd_bank;
        rd_ptr_d    = rd_ptr;
        ready_d     = BRAM_ready_mask;
        drain_start = 1'b0;
        rd_last     = 1'b0;

        case (rd_state)
            RD_IDLE: begin
                // Banks fill strictly in turn, so rd_bank is always the
                // oldest full bank. Looking at fill_done lets ready rise
                // on the same edge that stores the final beat.
                if (bank_q[rd_bank] == B_FULL || (fill_done && wr_bank == rd_bank)) begin
                    drain_start = 1'b1;
                    rd_state_d  = RD_DRAIN;
                    ready_d     = 1'b1;
                end
            end
            RD_DRAIN: begin
                if (rd_fire) begin
                    rd_ptr_d = rd_ptr + PW'(1);
                    if (rd_ptr == PW'(NUM_CHANNELS)) begin
                        rd_last    = 1'b1;
                        rd_ptr_d   = '0;
                        rd_bank_d  = ~rd_bank;
                        ready_d    = 1'b0;
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign rd_chan = CW'(rd_ptr - PW'(1));
    assign rd_addr = rd_bank ? AW'(NUM_CHANNELS) + AW'(rd_chan) : AW'(rd_chan);

    // ---------------- bank status ----------------
    // Later assignments win: a block may finish filling and start draining on
    // the same edge, and release/completion on different banks are independent.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (fill_start && wr_bank == 1'(b))  bank_d[b] = B_FILLING;
            if (fill_done && wr_bank == 1'(b))   bank_d[b] = B_FULL;
            if (drain_start && rd_bank == 1'(b)) bank_d[b] = B_DRAINING;
            if (rd_last && rd_bank == 1'(b))     bank_d[b] = B_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]       <= B_EMPTY;
            bank_q[1]       <= B_EMPTY;
            wr_state        <= WR_IDLE;
            wr_bank         <= 1'b0;
            chan_cnt        <= '0;
            time_idx        <= '0;
            rd_state        <= RD_IDLE;
            rd_bank         <= 1'b0;
            rd_ptr          <= '0;
            BRAM_ready_mask <= 1'b0;
            BRAM_rd_data    <= '0;
            overflow        <= 1'b0;
            seq_error       <= 1'b0;
            drop_count      <= '0;
        end else begin
            bank_q[0]       <= bank_d[0];
            bank_q[1]       <= bank_d[1];
            wr_state        <= wr_state_d;
            wr_bank         <= wr_bank_d;
            chan_cnt        <= chan_cnt_d;
            time_idx        <= time_idx_d;
            rd_state        <= rd_state_d;
            rd_bank         <= rd_bank_d;
            rd_ptr          <= rd_ptr_d;
            BRAM_ready_mask <= ready_d;

            if (rd_fire) begin
                if (rd_ptr == '0)
                    BRAM_rd_data <= {{(W-TS_WIDTH){1'b0}}, ts_q[rd_bank]};
                else
                    BRAM_rd_data <= mem[rd_addr];
            end

            // Status events take priority over a coincident clear.
            if (drop_evt)          overflow <= 1'b1;
            else if (clear_status) overflow <= 1'b0;

            if (seq_evt)           seq_error <= 1'b1;
            else if (clear_status) seq_error <= 1'b0;

            if (drop_evt) begin
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end else if (clear_status) begin
                drop_count <= '0;
            end
        end
    end

endmodule
